// File: rtl/pc_call_ctrl.sv
// pc_call_ctrl: program-counter owner and call/return initiator.
// It executes PC-update commands (STEP1, STEP2, JUN, JMS, BBL), owns the PC,
// drives push/pop/pcIn to an external 8-level return stack, and tracks the
// nesting depth locally. The fault flag and faultCode are sticky, and
// faultCode keeps the first fault that occurred.
//
// Ports:
//   clk, rstN            clock (rising edge), asynchronous active-low reset
//   cmdValid/cmd/target  command from the decoder. Codes 5-7 act as STEP1.
//   cmdReady             combinational, high only in IDLE
//   clrFault             synchronous clear of fault/faultCode
//   pc, done             current PC; 1-cycle pulse when a command retires
//   push, pop, pcIn      return-stack requests and the return address to push
//   stackPcOut           stack top (the pre-pop value during the pop cycle)
//   stackPcLoad          stack response, one cycle after an accepted pop
//   depth                current nesting depth, 0..MAX_DEPTH
//   fault, faultCode     01 overflow, 10 underflow, 11 missing stackPcLoad
//
// state | meaning
// IDLE  | ready; STEP/JUN and the fault paths retire in one edge
// PUSH  | push is asserted; the next edge jumps to the call target
// POP   | pop is asserted; the next edge latches the stack top
// WAIT  | waits one edge for stackPcLoad, then retires the return
module pc_call_ctrl #(
   parameter int AW        = 12,
   parameter int MAX_DEPTH = 7
) (
   input  logic          clk,
   input  logic          rstN,
   input  logic          cmdValid,
   input  logic [2:0]    cmd,
   input  logic [AW-1:0] target,
   output logic          cmdReady,
   input  logic          clrFault,
   output logic [AW-1:0] pc,
   output logic          done,
   output logic          push,
   output logic          pop,
   output logic [AW-1:0] pcIn,
   input  logic [AW-1:0] stackPcOut,
   input  logic          stackPcLoad,
   output logic [2:0]    depth,
   output logic          fault,
   output logic [1:0]    faultCode
);

   localparam logic [2:0] CMD_STEP2 = 3'd1;
   localparam logic [2:0] CMD_JUN   = 3'd2;
   localparam logic [2:0] CMD_JMS   = 3'd3;
   localparam logic [2:0] CMD_BBL   = 3'd4;
   localparam logic [2:0] MAXD      = 3'(MAX_DEPTH);

   localparam logic [1:0] FC_OVF  = 2'b01;
   localparam logic [1:0] FC_UNF  = 2'b10;
   localparam logic [1:0] FC_LOAD = 2'b11;

   typedef enum logic [1:0] {IDLE, PUSH, POP, WAIT} state_t;

   state_t        state, state_nx;
   logic [AW-1:0] pc_nx, pcIn_nx, tgt, tgt_nx, ret, ret_nx;
   logic [2:0]    depth_nx;
   logic          done_nx, push_nx, pop_nx, fault_nx;
   logic [1:0]    faultCode_nx;
   logic          setFault;
   logic [1:0]    newCode;

   assign cmdReady = (state == IDLE);

   always_comb begin
      state_nx     = state;
      pc_nx        = pc;
      pcIn_nx      = pcIn;
      tgt_nx       = tgt;
      ret_nx       = ret;
      depth_nx     = depth;
      done_nx      = 1'b0;
      push_nx      = 1'b0;
      pop_nx       = 1'b0;
      setFault     = 1'b0;
      newCode      = 2'b00;

      case (state)
         IDLE: begin
            if (cmdValid) begin
               done_nx = 1'b1;
               case (cmd)
                  CMD_STEP2: pc_nx = pc + AW'(2);
                  CMD_JUN:   pc_nx = target;
                  CMD_JMS: begin
                     if (depth < MAXD) begin
                        done_nx  = 1'b0;
                        push_nx  = 1'b1;
                        pcIn_nx  = pc + AW'(2);
                        tgt_nx   = target;
                        state_nx = PUSH;
                     end else begin
                        // Stack is full: jump anyway, without a return address.
                        pc_nx    = target;
                        setFault = 1'b1;
                        newCode  = FC_OVF;
                     end
                  end
                  CMD_BBL: begin
                     if (depth != 3'd0) begin
                        done_nx  = 1'b0;
                        pop_nx   = 1'b1;
                        state_nx = POP;
                     end else begin
                        pc_nx    = pc + AW'(1);
                        setFault = 1'b1;
                        newCode  = FC_UNF;
                     end
                  end
                  default: pc_nx = pc + AW'(1);
               endcase
            end
         end
         PUSH: begin
            pc_nx    = tgt;
            depth_nx = depth + 3'd1;
            done_nx  = 1'b1;
            state_nx = IDLE;
         end
         POP: begin
            // The stack shows its pre-pop top during the pop cycle.
            ret_nx   = stackPcOut;
            depth_nx = depth - 3'd1;
            state_nx = WAIT;
         end
         WAIT: begin
            done_nx  = 1'b1;
            state_nx = IDLE;
            if (stackPcLoad) begin
               pc_nx = ret;
            end else begin
               pc_nx    = pc + AW'(1);
               setFault = 1'b1;
               newCode  = FC_LOAD;
            end
         end
         default: state_nx = IDLE;
      endcase

      fault_nx     = fault;
      faultCode_nx = faultCode;
      if (clrFault) begin
         fault_nx     = 1'b0;
         faultCode_nx = 2'b00;
      end else if (setFault) begin
         fault_nx = 1'b1;
         if (faultCode == 2'b00) faultCode_nx = newCode;
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state     <= IDLE;
         pc        <= '0;
         pcIn      <= '0;
         tgt       <= '0;
         ret       <= '0;
         depth     <= 3'd0;
         done      <= 1'b0;
         push      <= 1'b0;
         pop       <= 1'b0;
         fault     <= 1'b0;
         faultCode <= 2'b00;
      end else begin
         state     <= state_nx;
         pc        <= pc_nx;
         pcIn      <= pcIn_nx;
         tgt       <= tgt_nx;
         ret       <= ret_nx;
         depth     <= depth_nx;
         done      <= done_nx;
         push      <= push_nx;
         pop       <= pop_nx;
         fault     <= fault_nx;
         faultCode <= faultCode_nx;
      end
   end

endmodule

// File: tb/tb_pc_call_ctrl.sv
module tb_pc_call_ctrl;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        cmdValid = 1'b0;
   logic [2:0]  cmd = 3'd0;
   logic [11:0] target = '0;
   logic        cmdReady;
   logic        clrFault = 1'b0;
   logic [11:0] pc;
   logic        done, push, pop;
   logic [11:0] pcIn;
   logic [11:0] stackPcOut;
   logic        stackPcLoad;
   logic [2:0]  depth;
   logic        fault;
   logic [1:0]  faultCode;

   int tests = 0;
   int failed = 0;

   logic [17:0] expq[$];
   logic [11:0] pushq[$];
   logic [11:0] popq[$];

   logic [11:0] stk[8];
   int          sp;
   logic        suppress = 1'b0;

   always #5 clk = ~clk;

   pc_call_ctrl #(.AW(12), .MAX_DEPTH(7)) dut (
      .clk(clk), .rstN(rstN), .cmdValid(cmdValid), .cmd(cmd), .target(target),
      .cmdReady(cmdReady), .clrFault(clrFault), .pc(pc), .done(done),
      .push(push), .pop(pop), .pcIn(pcIn), .stackPcOut(stackPcOut),
      .stackPcLoad(stackPcLoad), .depth(depth), .fault(fault), .faultCode(faultCode)
   );

   // Return stack model
   assign stackPcOut = (sp > 0) ? stk[sp-1] : 12'h000;
   always @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         sp          <= 0;
         stackPcLoad <= 1'b0;
      end else begin
         stackPcLoad <= pop & ~suppress;
         if (push && sp < 8) begin
            stk[sp] <= pcIn;
            sp      <= sp + 1;
         end
         if (pop && sp > 0) sp <= sp - 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [17:0] ex(input logic [11:0] p, input logic [2:0] d,
                                      input logic f, input logic [1:0] c);
      return {p, d, f, c};
   endfunction

   // Monitor: compare every DUT-presented event against the queued expectations
   logic prevPush = 1'b0;
   always @(negedge clk) begin
      if (rstN) begin
         if (push && pop) chk("push_pop_overlap", 32'(1), 32'(0));
         if (push) begin
            if (prevPush) chk("push_width", 32'(2), 32'(1));
            if (pushq.size() == 0) chk("unexpected_push", 32'(pcIn), 32'hFFFF_FFFF);
            else chk("pcIn", 32'(pcIn), 32'(pushq.pop_front()));
         end
         if (pop) begin
            if (popq.size() == 0) chk("unexpected_pop", 32'(stackPcOut), 32'hFFFF_FFFF);
            else chk("stackPcOut_at_pop", 32'(stackPcOut), 32'(popq.pop_front()));
         end
         if (done) begin
            if (expq.size() == 0) chk("unexpected_done", 32'({pc, depth, fault, faultCode}), 32'hFFFF_FFFF);
            else chk("done_state{pc,depth,fault,code}", 32'({pc, depth, fault, faultCode}), 32'(expq.pop_front()));
         end
      end
      prevPush <= push;
   end

   task automatic issue(input logic [2:0] c, input logic [11:0] t);
      int n = 0;
      @(negedge clk);
      while (!cmdReady && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!cmdReady) chk("issue_timeout", 32'(0), 32'(1));
      cmdValid = 1'b1;
      cmd      = c;
      target   = t;
      @(posedge clk);
      #1;
      cmdValid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((expq.size() != 0 || !cmdReady) && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("drain_pending", 32'(expq.size() + pushq.size() + popq.size()), 32'(0));
   endtask

   task automatic clear_fault();
      @(negedge clk);
      clrFault = 1'b1;
      @(negedge clk);
      clrFault = 1'b0;
      chk("fault_after_clr", 32'(fault), 32'(0));
      chk("faultCode_after_clr", 32'(faultCode), 32'(0));
   endtask

   initial begin
      logic [11:0] r;
      repeat (3) @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);
      // Reset state
      chk("rst_pc", 32'(pc), 32'h000);
      chk("rst_depth", 32'(depth), 32'(0));
      chk("rst_cmdReady", 32'(cmdReady), 32'(1));
      chk("rst_fault", 32'(fault), 32'(0));
      chk("rst_push_pop", 32'({push, pop}), 32'(0));

      // Call / return round trip
      expq.push_back(ex(12'h123, 3'd0, 1'b0, 2'b00));
      issue(3'd2, 12'h123);
      pushq.push_back(12'h125);
      expq.push_back(ex(12'h456, 3'd1, 1'b0, 2'b00));
      issue(3'd3, 12'h456);
      popq.push_back(12'h125);
      expq.push_back(ex(12'h125, 3'd0, 1'b0, 2'b00));
      issue(3'd4, 12'h000);
      drain();

      // Seven nested calls, an overflowing eighth, then seven returns
      expq.push_back(ex(12'h010, 3'd0, 1'b0, 2'b00));
      issue(3'd2, 12'h010);
      for (int i = 1; i <= 7; i++) begin
         r = (i == 1) ? 12'h012 : 12'((i - 1) * 256 + 2);
         pushq.push_back(r);
         expq.push_back(ex(12'(i * 256), 3'(i), 1'b0, 2'b00));
         issue(3'd3, 12'(i * 256));
      end
      expq.push_back(ex(12'h200, 3'd7, 1'b1, 2'b01));
      issue(3'd3, 12'h200);
      for (int k = 1; k <= 7; k++) begin
         r = (k == 7) ? 12'h012 : 12'((7 - k) * 256 + 2);
         popq.push_back(r);
         expq.push_back(ex(r, 3'(7 - k), 1'b1, 2'b01));
         issue(3'd4, 12'h000);
      end
      drain();
      clear_fault();

      // Underflow
      expq.push_back(ex(12'h010, 3'd0, 1'b0, 2'b00));
      issue(3'd2, 12'h010);
      expq.push_back(ex(12'h011, 3'd0, 1'b1, 2'b10));
      issue(3'd4, 12'h000);
      drain();
      clear_fault();

      // Missing stackPcLoad
      expq.push_back(ex(12'h300, 3'd0, 1'b0, 2'b00));
      issue(3'd2, 12'h300);
      pushq.push_back(12'h302);
      expq.push_back(ex(12'h400, 3'd1, 1'b0, 2'b00));
      issue(3'd3, 12'h400);
      drain();
      suppress = 1'b1;
      popq.push_back(12'h302);
      expq.push_back(ex(12'h401, 3'd0, 1'b1, 2'b11));
      issue(3'd4, 12'h000);
      drain();
      suppress = 1'b0;
      clear_fault();

      // Wrap-around and unused command codes
      expq.push_back(ex(12'hFFF, 3'd0, 1'b0, 2'b00));
      issue(3'd2, 12'hFFF);
      expq.push_back(ex(12'h001, 3'd0, 1'b0, 2'b00));
      issue(3'd1, 12'h000);
      expq.push_back(ex(12'hFFF, 3'd0, 1'b0, 2'b00));
      issue(3'd2, 12'hFFF);
      expq.push_back(ex(12'h000, 3'd0, 1'b0, 2'b00));
      issue(3'd0, 12'h000);
      expq.push_back(ex(12'h001, 3'd0, 1'b0, 2'b00));
      issue(3'd5, 12'h777);
      expq.push_back(ex(12'h002, 3'd0, 1'b0, 2'b00));
      issue(3'd7, 12'h777);
      expq.push_back(ex(12'hFFE, 3'd0, 1'b0, 2'b00));
      issue(3'd2, 12'hFFE);
      pushq.push_back(12'h000);
      expq.push_back(ex(12'h050, 3'd1, 1'b0, 2'b00));
      issue(3'd3, 12'h050);
      drain();

      // Reset during the pop cycle of a BBL
      issue(3'd4, 12'h000);
      chk("pop_before_reset", 32'(pop), 32'(1));
      #1 rstN = 1'b0;
      #1;
      chk("reset_pop", 32'(pop), 32'(0));
      chk("reset_pc", 32'(pc), 32'h000);
      chk("reset_cmdReady", 32'(cmdReady), 32'(1));
      chk("reset_depth", 32'(depth), 32'(0));
      @(negedge clk);
      rstN = 1'b1;

      // clrFault wins over an underflow in the same cycle
      clrFault = 1'b1;
      expq.push_back(ex(12'h001, 3'd0, 1'b0, 2'b00));
      issue(3'd4, 12'h000);
      drain();
      clrFault = 1'b0;

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
